// File: rtl/pmem_responder.sv
// Line-granular memory model that answers read/write line requests after a fixed latency.
// A three-state controller latches the request at accept and flags protocol violations.
module pmem_responder #(
    parameter int LATENCY = 4,
    parameter int LINES   = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         pmem_read,
    input  logic         pmem_write,
    input  logic [31:0]  pmem_address,
    input  logic [255:0] pmem_wdata,
    output logic [255:0] pmem_rdata,
    output logic         pmem_resp,
    output logic         protocol_err
);

    localparam int IDX_W = $clog2(LINES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             state_r;
    logic [3:0]         cnt_r;
    logic [IDX_W-1:0]   idx_r;
    logic               is_write_r;
    logic [255:0]       wdata_r;
    logic [255:0]       mem_r [LINES];

    logic [IDX_W-1:0]   req_idx_s;
    logic               req_s;
    logic               unused_addr_s;

    assign req_idx_s     = pmem_address[4+IDX_W:5];
    assign req_s         = pmem_read | pmem_write;
    assign unused_addr_s = ^{pmem_address[31:5+IDX_W], pmem_address[4:0]};

    // Controller, latched request, storage array and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 4'd0;
            idx_r        <= '0;
            is_write_r   <= 1'b0;
            wdata_r      <= 256'd0;
            pmem_rdata   <= 256'd0;
            pmem_resp    <= 1'b0;
            protocol_err <= 1'b0;
            for (int i = 0; i < LINES; i++) begin
                mem_r[i] <= 256'd0;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    pmem_resp <= 1'b0;
                    if (req_s) begin
                        idx_r      <= req_idx_s;
                        is_write_r <= pmem_write;
                        wdata_r    <= pmem_wdata;
                        // A simultaneous read and write is served as a write.
                        if (pmem_read && pmem_write) begin
                            protocol_err <= 1'b1;
                        end else begin
                            protocol_err <= protocol_err;
                        end
                        if (LATENCY == 1) begin
                            state_r   <= ST_RESP;
                            cnt_r     <= 4'd0;
                            pmem_resp <= 1'b1;
                            if (!pmem_write) begin
                                pmem_rdata <= mem_r[req_idx_s];
                            end else begin
                                pmem_rdata <= pmem_rdata;
                            end
                        end else begin
                            state_r <= ST_BUSY;
                            cnt_r   <= 4'(LATENCY - 1);
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    // Initiator withdrew the request: abandon without response or write.
                    if (!req_s) begin
                        state_r      <= ST_IDLE;
                        cnt_r        <= 4'd0;
                        protocol_err <= 1'b1;
                        pmem_resp    <= 1'b0;
                    end else if (cnt_r <= 4'd1) begin
                        state_r   <= ST_RESP;
                        cnt_r     <= 4'd0;
                        pmem_resp <= 1'b1;
                        if (!is_write_r) begin
                            pmem_rdata <= mem_r[idx_r];
                        end else begin
                            pmem_rdata <= pmem_rdata;
                        end
                    end else begin
                        cnt_r     <= cnt_r - 4'd1;
                        pmem_resp <= 1'b0;
                    end
                end
                ST_RESP: begin
                    state_r   <= ST_IDLE;
                    pmem_resp <= 1'b0;
                    if (is_write_r) begin
                        mem_r[idx_r] <= wdata_r;
                    end else begin
                        mem_r[idx_r] <= mem_r[idx_r];
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    cnt_r     <= 4'd0;
                    pmem_resp <= 1'b0;
                end
            endcase
        end
    end

endmodule
